// File: rtl/matrix_write_arbiter.sv
// matrix_write_arbiter
//   Round-robin arbiter that merges NUM_REQ packetised write streams into a
//   single registered RAM write port. Once a requester wins with a non-final
//   beat it owns the port until its last beat is accepted. Single-beat
//   packets never leave IDLE, so back-to-back packets run at one beat/cycle.
//
// Parameters
//   NUM_REQ  number of write requesters (2..4)
//   ADDR_W   RAM write address width
//   DATA_W   RAM write data width
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req_valid/last     per-requester beat valid / final-beat flag
//   req_addr/data      per-requester beat, requester i at [i*W +: W]
//   req_ready          per-requester accept (combinational)
//   abort              drop ownership, no accept this cycle
//   ram_wr_en/addr/data registered RAM write, one cycle after accept
//   grant_id           requester index of the most recent accept
//   busy               high while a multi-beat packet owns the port
//   stats_clr, wr_count (only with MATRIX_WRITE_ARB_STATS_EN) per-requester
//                      saturating 12-bit beat counters, synchronous clear
//
// Build option: define MATRIX_WRITE_ARB_STATS_EN to add the beat counters.

`ifdef MATRIX_WRITE_ARB_STATS_EN
// Per-requester saturating beat counter; clear beats a same-cycle increment.
module mwa_stat_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [11:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst || clr)                cnt <= '0;
    else if (inc && cnt != 12'hFFF) cnt <= cnt + 12'd1;
  end
endmodule
`endif

module matrix_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      abort,
  output logic                      ram_wr_en,
  output logic [ADDR_W-1:0]         ram_wr_addr,
  output logic [DATA_W-1:0]         ram_wr_data,
  output logic [1:0]                grant_id,
  output logic                      busy
`ifdef MATRIX_WRITE_ARB_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [NUM_REQ*12-1:0]     wr_count
`endif
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);
  localparam logic [2:0] NREQ3    = 3'(NUM_REQ);

  typedef enum logic { IDLE = 1'b0, BURST = 1'b1 } state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        id;
  } wr_t;

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] rr_ptr, rr_ptr_nxt;
  wr_t        wr_q;

  // Requester views padded to 4 entries so a 2-bit index is always in range.
  logic [3:0]             valid4, last4, ready4;
  logic [3:0][ADDR_W-1:0] addr4;
  logic [3:0][DATA_W-1:0] data4;

  always_comb begin
    valid4 = '0;
    last4  = '0;
    addr4  = '0;
    data4  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid4[i] = req_valid[i];
      last4[i]  = req_last[i];
      addr4[i]  = req_addr[i*ADDR_W +: ADDR_W];
      data4[i]  = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  logic [1:0] winner;
  logic       win_vld;
  logic [2:0] sum;

  always_comb begin
    winner  = '0;
    win_vld = 1'b0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + 3'(k);
      if (sum >= NREQ3) sum = sum - NREQ3;
      if (!win_vld && valid4[sum[1:0]]) begin
        winner  = sum[1:0];
        win_vld = 1'b1;
      end
    end
  end

  // Next-state / grant logic. sel is the single requester that may be
  // granted this cycle: the search winner in IDLE, the owner in BURST.
  logic [1:0] sel;
  logic       grant_ok;
  logic       accept;

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    sel        = winner;
    grant_ok   = 1'b0;
    accept     = 1'b0;
    ready4     = '0;

    case (state)
      IDLE:    begin sel = winner; grant_ok = win_vld; end
      BURST:   begin sel = owner;  grant_ok = 1'b1;    end
      default: begin sel = winner; grant_ok = 1'b0;    end
    endcase

    if (rst || abort) grant_ok = 1'b0;

    // Owner sees ready even with valid low; that just stalls the burst.
    if (grant_ok) ready4 = 4'b0001 << sel;
    accept = grant_ok && valid4[sel];

    if (accept) begin
      if (last4[sel]) begin
        state_nxt  = IDLE;
        rr_ptr_nxt = (sel == LAST_IDX) ? 2'd0 : sel + 2'd1;
      end else begin
        state_nxt = BURST;
        owner_nxt = sel;
      end
    end

    if (abort) state_nxt = IDLE;
  end

  assign req_ready = ready4[NUM_REQ-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      wr_q   <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      rr_ptr  <= rr_ptr_nxt;
      wr_q.en <= accept;
      // Address/data/id hold their last value between writes.
      if (accept) begin
        wr_q.addr <= addr4[sel];
        wr_q.data <= data4[sel];
        wr_q.id   <= sel;
      end
    end
  end

  assign ram_wr_en   = wr_q.en;
  assign ram_wr_addr = wr_q.addr;
  assign ram_wr_data = wr_q.data;
  assign grant_id    = wr_q.id;
  assign busy        = (state == BURST);

`ifdef MATRIX_WRITE_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    mwa_stat_ctr u_ctr (
      .clk (clk),
      .rst (rst),
      .clr (stats_clr),
      .inc (accept && (sel == 2'(i))),
      .cnt (wr_count[i*12 +: 12])
    );
  end
`endif

endmodule

// File: doc/matrix_write_arbiter.md
MATRIX_WRITE_ARBITER -- requirements
Module: matrix_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of write requesters (2..4).
REQ-002 SHALL have parameter ADDR_W, default 11, RAM write address width.
REQ-003 SHALL have parameter DATA_W, default 32, RAM write data width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester write beat valid.
REQ-007 SHALL have port req_addr  input  NUM_REQ*ADDR_W  per-requester beat address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_W  per-requester beat data, same packing.
REQ-009 SHALL have port req_last  input  NUM_REQ  beat is final beat of the requester's packet.
REQ-010 SHALL have port req_ready  output  NUM_REQ  beat accepted this cycle when valid and ready both high.
REQ-011 SHALL have port abort  input  1  drop current ownership, return to IDLE.
REQ-012 SHALL have port ram_wr_en  output  1  registered RAM write enable.
REQ-013 SHALL have port ram_wr_addr  output  ADDR_W  registered RAM write address.
REQ-014 SHALL have port ram_wr_data  output  DATA_W  registered RAM write data.
REQ-015 SHALL have port grant_id  output  2  index of current or most recent owner.
REQ-016 SHALL have port busy  output  1  high while in BURST state.

Function
REQ-017 SHALL implement states IDLE and BURST; owner register and round-robin pointer rr_ptr (0..NUM_REQ-1).
REQ-018 In IDLE, winner SHALL be the first index with req_valid high, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ; req_ready SHALL be high only for the winner (combinational from req_valid, state, rr_ptr).
REQ-019 In BURST, req_ready SHALL be high only for owner, regardless of its req_valid; all other requesters stall.
REQ-020 Accept in IDLE with req_last=0 SHALL move to BURST, owner=winner; with req_last=1, SHALL stay IDLE (single-beat packet).
REQ-021 Accept in BURST with req_last=1 SHALL return to IDLE; owner deasserting req_valid mid-burst SHALL hold BURST with no write.
REQ-022 On every accepted last beat by requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; otherwise rr_ptr unchanged.
REQ-023 Each accepted beat SHALL appear on ram_wr_en/ram_wr_addr/ram_wr_data exactly 1 cycle later; ram_wr_en SHALL be low in any cycle following no accept; addr/data hold last value when not writing.
REQ-024 grant_id SHALL update to the accepting requester index on each accept, registered alongside ram_wr_en.
REQ-025 abort SHALL, that cycle, force all req_ready low, no accept, next state IDLE, rr_ptr unchanged; a write registered the previous cycle still completes.
REQ-026 Throughput SHALL be one beat per cycle, including back-to-back packets from different requesters with no idle cycle between them.
REQ-027 No input valid in IDLE SHALL leave all state unchanged.

Reset
REQ-028 rst SHALL set state IDLE, owner 0, rr_ptr 0, ram_wr_en 0, ram_wr_addr 0, ram_wr_data 0, grant_id 0, busy 0, all statistics 0.
REQ-029 rst asserted mid-burst SHALL discard the burst; req_ready all low during reset cycles.

Configuration
REQ-030 Macro MATRIX_WRITE_ARB_STATS_EN, when defined, SHALL add input stats_clr (1) and output wr_count (NUM_REQ*12), a per-requester count of accepted beats, saturating at 4095, cleared synchronously by stats_clr (clear wins over same-cycle increment).
REQ-031 Without MATRIX_WRITE_ARB_STATS_EN, stats_clr and wr_count SHALL not exist and no counter logic SHALL be synthesized; all other behaviour identical.

Verification
REQ-032 Single beat: req_valid=01, addr0=5, data0=0xDEAD, last0=1 -> ready=01 same cycle; next cycle ram_wr_en=1, addr=5, data=0xDEAD, grant_id=0; rr_ptr=1.
REQ-033 Contention: both valid, single-beat, rr_ptr=0 -> req0 accepted first, req1 next cycle; ram_wr_en high 2 consecutive cycles, grant_id 0 then 1.
REQ-034 Burst lock: req0 sends 3-beat packet (addr 10,11,12), req1 valid throughout -> req1 ready low for 3 cycles, busy high cycles 2-3, req1 accepted cycle 4.
REQ-035 Stall: req0 drops valid for 2 cycles mid-burst -> busy stays 1, ram_wr_en 0 for those 2 cycles, req1 never ready.
REQ-036 Abort mid-burst after 1 of 4 beats -> next cycle IDLE, busy 0, rr_ptr unchanged; rst mid-burst -> all outputs 0 next cycle.
REQ-037 With MATRIX_WRITE_ARB_STATS_EN: 4100 beats from req1 -> wr_count[1]=4095; stats_clr -> 0.
